// File: rtl/ccip_rd_stream_pkg.sv
// ----------------------------------------------------------------------------
// ccip_rd_stream_pkg
//
// Shared types and constants for the CCI-P c0 streaming read engine.
//   - t_rd_stream_state : engine control states
//   - t_line_count      : 32-bit line counter type (request index, line totals)
//   - CHECKSUM_WIDTH    : width of one folded response word
//   - LINE_WIDTH        : width of one CCI-P cache line
//   - fold_line()       : XOR of the 64-bit words of one cache line
// ----------------------------------------------------------------------------
package ccip_rd_stream_pkg;

    localparam int CHECKSUM_WIDTH = 64;
    localparam int LINE_WIDTH     = 512;
    localparam int LINE_WORDS     = LINE_WIDTH / CHECKSUM_WIDTH;

    typedef logic [31:0] t_line_count;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } t_rd_stream_state;

    // Fold a full cache line down to one checksum word.
    function automatic logic [CHECKSUM_WIDTH-1:0] fold_line(
        input logic [LINE_WIDTH-1:0] line
    );
        logic [CHECKSUM_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            acc = acc ^ line[i*CHECKSUM_WIDTH +: CHECKSUM_WIDTH];
        end
        return acc;
    endfunction

endpackage : ccip_rd_stream_pkg

// File: rtl/ccip_rd_stream_credit_counter.sv
// ----------------------------------------------------------------------------
// ccip_rd_stream_credit_counter
//
// Tracks read requests that have been issued but not yet answered.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   inc        in   one request issued this cycle
//   dec        in   one response presented this cycle
//   at_limit   out  count has reached MAX_COUNT; no further issue allowed
//   zero       out  nothing outstanding
//   underflow  out  dec presented while nothing is outstanding (not applied)
//
// A simultaneous inc and valid dec leave the count unchanged. A dec with a
// zero count is flagged and discarded so the count never wraps.
// ----------------------------------------------------------------------------
module ccip_rd_stream_credit_counter #(
    parameter int MAX_COUNT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    output logic at_limit,
    output logic zero,
    output logic underflow
);

    localparam int CNT_WIDTH = $clog2(MAX_COUNT) + 1;

    logic [CNT_WIDTH-1:0] count_q;
    logic                 dec_ok;

    assign zero      = (count_q == '0);
    assign at_limit  = (count_q == CNT_WIDTH'(MAX_COUNT));
    assign underflow = dec && zero;
    assign dec_ok    = dec && !zero;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && !dec_ok) begin
            count_q <= count_q + 1'b1;
        end else if (!inc && dec_ok) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule : ccip_rd_stream_credit_counter

// File: rtl/ccip_rd_stream_engine.sv
// ----------------------------------------------------------------------------
// ccip_rd_stream_engine
//
// Streaming read engine on the CCI-P c0 channel. A start command launches a
// run of sequential cache-line reads from base_addr. Requests are throttled
// by c0 almost-full and by a local cap on outstanding reads; returned lines
// are counted and (optionally) XOR-folded into a checksum.
//
// Ports:
//   clk, reset_n       clock; synchronous active-low reset
//   start              start pulse, accepted in IDLE only
//   base_addr          first cache-line address (sampled on accepted start)
//   num_lines          number of lines to read (sampled on accepted start)
//   c0_req_valid       registered read request strobe
//   c0_req_addr        request line address, base_addr + index (wraps)
//   c0_req_mdata       request tag, low MDATA_WIDTH bits of the index
//   c0_alm_full        c0 almost-full from the shim; blocks issue
//   c0_rsp_valid       read response strobe
//   c0_rsp_data        read response line
//   busy               run in progress (RUN or DRAIN)
//   done               one-cycle completion pulse
//   lines_rcvd         responses counted in the current/last run
//   cycles             busy cycles of the current/last run, saturating
//   checksum           XOR fold of counted responses
//   err_unexpected     sticky: response while busy with nothing outstanding
//
// Build option:
//   CCIP_RD_STREAM_CHECKSUM_EN  defined  -> checksum accumulator is built
//                               undefined -> checksum is tied to zero
// ----------------------------------------------------------------------------
module ccip_rd_stream_engine
    import ccip_rd_stream_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_WIDTH      = 42,
    parameter int MDATA_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [31:0]               num_lines,
    output logic                      c0_req_valid,
    output logic [ADDR_WIDTH-1:0]     c0_req_addr,
    output logic [MDATA_WIDTH-1:0]    c0_req_mdata,
    input  logic                      c0_alm_full,
    input  logic                      c0_rsp_valid,
    input  logic [LINE_WIDTH-1:0]     c0_rsp_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               lines_rcvd,
    output logic [31:0]               cycles,
    output logic [CHECKSUM_WIDTH-1:0] checksum,
    output logic                      err_unexpected
);

    t_rd_stream_state      state_q;
    t_rd_stream_state      state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    t_line_count           num_q;
    t_line_count           issued_q;

    logic start_accept;
    logic issue;
    logic last_issue;
    logic rsp_live;
    logic rsp_count;
    logic rsp_underflow;
    logic credit_at_limit;
    logic credit_zero;

    // ------------------------------------------------------------------
    // Status decode straight from the state register
    // ------------------------------------------------------------------
    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

    assign start_accept = start && (state_q == ST_IDLE);

    // Issue decision for this cycle; the request itself appears on the
    // c0 outputs one cycle later. Almost-full is honoured in the same cycle.
    assign issue = (state_q == ST_RUN)
                && (issued_q < num_q)
                && !credit_at_limit
                && !c0_alm_full;

    assign last_issue = issue && (issued_q == num_q - 32'd1);

    // Responses outside a run are dropped before they reach any counter.
    assign rsp_live  = c0_rsp_valid && busy;
    assign rsp_count = rsp_live && !credit_zero;

    // ------------------------------------------------------------------
    // Outstanding-request tracking
    // ------------------------------------------------------------------
    ccip_rd_stream_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (issue),
        .dec       (rsp_live),
        .at_limit  (credit_at_limit),
        .zero      (credit_zero),
        .underflow (rsp_underflow)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = (num_lines == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (lines_rcvd == num_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request and statistics registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            num_q          <= '0;
            issued_q       <= '0;
            c0_req_valid   <= 1'b0;
            c0_req_addr    <= '0;
            c0_req_mdata   <= '0;
            lines_rcvd     <= '0;
            cycles         <= '0;
            err_unexpected <= 1'b0;
        end else begin
            state_q      <= state_d;
            c0_req_valid <= issue;

            if (issue) begin
                c0_req_addr  <= base_q + ADDR_WIDTH'(issued_q);
                c0_req_mdata <= MDATA_WIDTH'(issued_q);
                issued_q     <= issued_q + 32'd1;
            end

            if (start_accept) begin
                base_q         <= base_addr;
                num_q          <= num_lines;
                issued_q       <= '0;
                lines_rcvd     <= '0;
                cycles         <= '0;
                err_unexpected <= 1'b0;
            end

            if (rsp_count) begin
                lines_rcvd <= lines_rcvd + 32'd1;
            end

            // Saturate rather than wrap on very long runs.
            if (busy && (cycles != 32'hFFFF_FFFF)) begin
                cycles <= cycles + 32'd1;
            end

            if (rsp_underflow) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum accumulator
    // ------------------------------------------------------------------
`ifdef CCIP_RD_STREAM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (start_accept) begin
            checksum <= '0;
        end else if (rsp_count) begin
            checksum <= checksum ^ fold_line(c0_rsp_data);
        end
    end
`else
    assign checksum = '0;

    // Response payload only feeds the checksum, which is not built here.
    logic rsp_data_unused;
    assign rsp_data_unused = ^c0_rsp_data;
`endif

endmodule : ccip_rd_stream_engine

// File: tb/tb_ccip_rd_stream_engine.sv
// ----------------------------------------------------------------------------
// tb_ccip_rd_stream_engine
//
// Self-checking bench for ccip_rd_stream_engine (MAX_OUTSTANDING = 4).
// A negedge process records every request, answers outstanding requests in
// random order with random lines, and keeps the expected checksum. Each
// scenario task drives stimulus and compares results against expectations
// derived from the run parameters.
// ----------------------------------------------------------------------------
module tb_ccip_rd_stream_engine;

    localparam int MAX_OUT     = 4;
    localparam int AW          = 42;
    localparam int MW          = 16;
    localparam int RUN_TIMEOUT = 3000;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [31:0]    num_lines = '0;
    logic           c0_req_valid;
    logic [AW-1:0]  c0_req_addr;
    logic [MW-1:0]  c0_req_mdata;
    logic           c0_alm_full = 1'b0;
    logic           c0_rsp_valid = 1'b0;
    logic [511:0]   c0_rsp_data = '0;
    logic           busy;
    logic           done;
    logic [31:0]    lines_rcvd;
    logic [31:0]    cycles;
    logic [63:0]    checksum;
    logic           err_unexpected;

    ccip_rd_stream_engine #(
        .MAX_OUTSTANDING (MAX_OUT),
        .ADDR_WIDTH      (AW),
        .MDATA_WIDTH     (MW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_lines      (num_lines),
        .c0_req_valid   (c0_req_valid),
        .c0_req_addr    (c0_req_addr),
        .c0_req_mdata   (c0_req_mdata),
        .c0_alm_full    (c0_alm_full),
        .c0_rsp_valid   (c0_rsp_valid),
        .c0_rsp_data    (c0_rsp_data),
        .busy           (busy),
        .done           (done),
        .lines_rcvd     (lines_rcvd),
        .cycles         (cycles),
        .checksum       (checksum),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Monitor / responder state
    logic [AW-1:0]  req_addr_q[$];
    logic [MW-1:0]  req_tag_q[$];
    int             req_cyc_q[$];
    logic [MW-1:0]  pend_q[$];
    logic [511:0]   line_q[$];
    int             rsp_pct      = 100;
    int             rsp_budget   = 1 << 30;
    bit             stray_req    = 1'b0;
    bit             alm_rand     = 1'b0;
    int             rsp_cnt      = 0;
    int             done_cnt     = 0;
    int             done_cyc     = 0;
    int             last_rsp_cyc = 0;
    int             max_inflight = 0;
    bit             busy_seen    = 1'b0;
    logic [63:0]    sum_acc      = '0;

    // Current run parameters
    int             start_cyc   = 0;
    int             done_before = 0;
    logic [AW-1:0]  exp_base    = '0;
    int             exp_n       = 0;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [63:0] fold8(input logic [511:0] l);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) acc = acc ^ l[i*64 +: 64];
        return acc;
    endfunction

    function automatic logic [63:0] exp_checksum(input logic [63:0] acc);
`ifdef CCIP_RD_STREAM_CHECKSUM_EN
        return acc;
`else
        return 64'h0;
`endif
    endfunction

    // Request monitor and out-of-order responder
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (c0_req_valid) begin
                req_addr_q.push_back(c0_req_addr);
                req_tag_q.push_back(c0_req_mdata);
                req_cyc_q.push_back(cyc);
                pend_q.push_back(c0_req_mdata);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            if (pend_q.size() > max_inflight) max_inflight = pend_q.size();
            c0_rsp_valid = 1'b0;
            if (stray_req) begin
                c0_rsp_valid = 1'b1;
                c0_rsp_data  = rand_line();
                stray_req    = 1'b0;
            end else if (pend_q.size() > 0 && rsp_budget > 0 &&
                         $urandom_range(0, 99) < rsp_pct) begin
                idx = $urandom_range(0, pend_q.size() - 1);
                pend_q.delete(idx);
                c0_rsp_data  = (line_q.size() > 0) ? line_q.pop_front() : rand_line();
                c0_rsp_valid = 1'b1;
                sum_acc      = sum_acc ^ fold8(c0_rsp_data);
                rsp_cnt++;
                rsp_budget--;
                last_rsp_cyc = cyc;
            end
            if (alm_rand) c0_alm_full = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [AW-1:0] b, input int n);
        req_addr_q.delete();
        req_tag_q.delete();
        req_cyc_q.delete();
        pend_q.delete();
        sum_acc      = '0;
        rsp_cnt      = 0;
        max_inflight = 0;
        busy_seen    = 1'b0;
        exp_base     = b;
        exp_n        = n;
        done_before  = done_cnt;
        tick();
        base_addr = b;
        num_lines = n;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // Waits for the run's done pulse, then compares every run-level result.
    task automatic finish_run(input string tag, input bit exp_err);
        int            waited;
        int            bad;
        logic [AW-1:0] ea;
        waited = 0;
        while (done_cnt == done_before && waited < RUN_TIMEOUT) begin
            tick();
            waited++;
        end
        n_total++;
        if (done_cnt == done_before) begin
            $display("FAIL %s_done: no done pulse within %0d cycles", tag, RUN_TIMEOUT);
        end else begin
            n_pass++;
            n_total++;
            if (req_addr_q.size() !== exp_n)
                $display("FAIL %s_req_count: got %0d want %0d", tag, req_addr_q.size(), exp_n);
            else n_pass++;
            bad = 0;
            for (int k = 0; k < req_addr_q.size(); k++) begin
                ea = exp_base + AW'(k);
                if (req_addr_q[k] !== ea || req_tag_q[k] !== MW'(k)) bad++;
            end
            n_total++;
            if (bad != 0) $display("FAIL %s_req_seq: %0d bad requests, want 0", tag, bad);
            else n_pass++;
            n_total++;
            if (lines_rcvd !== 32'(exp_n))
                $display("FAIL %s_lines: got %0d want %0d", tag, lines_rcvd, exp_n);
            else n_pass++;
            n_total++;
            if (checksum !== exp_checksum(sum_acc))
                $display("FAIL %s_checksum: got %h want %h", tag, checksum, exp_checksum(sum_acc));
            else n_pass++;
            n_total++;
            if (err_unexpected !== exp_err)
                $display("FAIL %s_err: got %b want %b", tag, err_unexpected, exp_err);
            else n_pass++;
            n_total++;
            if (cycles !== 32'(done_cyc - start_cyc - 1))
                $display("FAIL %s_cycles: got %0d want %0d", tag, cycles, done_cyc - start_cyc - 1);
            else n_pass++;
            if (exp_n > 0) begin
                n_total++;
                if (done_cyc - last_rsp_cyc != 2)
                    $display("FAIL %s_done_latency: got %0d want 2", tag, done_cyc - last_rsp_cyc);
                else n_pass++;
            end
            n_total++;
            if (max_inflight > MAX_OUT)
                $display("FAIL %s_inflight: got %0d want <= %0d", tag, max_inflight, MAX_OUT);
            else n_pass++;
            tick();
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0 || done_cnt != done_before + 1)
                $display("FAIL %s_after_done: done=%b busy=%b pulses=%0d want 0 0 1",
                         tag, done, busy, done_cnt - done_before);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if (c0_req_valid !== 1'b0 || c0_req_addr !== '0 || c0_req_mdata !== '0)
            $display("FAIL reset_req: valid=%b addr=%h mdata=%h want 0", c0_req_valid, c0_req_addr, c0_req_mdata);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        n_total++;
        if (lines_rcvd !== '0 || cycles !== '0 || checksum !== '0 || err_unexpected !== 1'b0)
            $display("FAIL reset_stats: lines=%0d cycles=%0d sum=%h err=%b want 0", lines_rcvd, cycles, checksum, err_unexpected);
        else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int bad;
        rsp_pct = 100;
        start_run(42'h100, 8);
        n_total++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
        else n_pass++;
        finish_run("basic", 1'b0);
        bad = (req_cyc_q.size() != 8) ? 1 : 0;
        for (int k = 0; k < req_cyc_q.size(); k++)
            if (req_cyc_q[k] != req_cyc_q[0] + k) bad++;
        n_total++;
        if (bad != 0) $display("FAIL basic_back_to_back: %0d gaps, want 0", bad);
        else n_pass++;
        n_total++;
        if (req_cyc_q.size() == 0 || req_cyc_q[0] < start_cyc + 1)
            $display("FAIL basic_first_req: got %0d requests, first too early or missing", req_cyc_q.size());
        else n_pass++;
    endtask

    task automatic test_cap();
        rsp_pct    = 100;
        rsp_budget = 0;
        start_run(42'h2000, 16);
        repeat (20) tick();
        n_total++;
        if (req_addr_q.size() != MAX_OUT)
            $display("FAIL cap_stall: got %0d requests want %0d", req_addr_q.size(), MAX_OUT);
        else n_pass++;
        rsp_budget = 1;
        repeat (10) tick();
        n_total++;
        if (req_addr_q.size() != MAX_OUT + 1)
            $display("FAIL cap_release: got %0d requests want %0d", req_addr_q.size(), MAX_OUT + 1);
        else n_pass++;
        rsp_budget = 1 << 30;
        finish_run("cap", 1'b0);
    endtask

    task automatic test_alm_full();
        int a;
        int waited;
        int in_window;
        bit resumed;
        rsp_pct = 100;
        start_run(42'h5000, 16);
        waited = 0;
        while (req_addr_q.size() < 5 && waited < 100) begin
            tick();
            waited++;
        end
        c0_alm_full = 1'b1;
        a = cyc;
        repeat (10) tick();
        c0_alm_full = 1'b0;
        finish_run("alm", 1'b0);
        in_window = 0;
        resumed   = 1'b0;
        foreach (req_cyc_q[k]) begin
            if (req_cyc_q[k] >= a + 1 && req_cyc_q[k] <= a + 10) in_window++;
            if (req_cyc_q[k] == a + 11) resumed = 1'b1;
        end
        n_total++;
        if (in_window != 0) $display("FAIL alm_blocked: got %0d requests want 0", in_window);
        else n_pass++;
        n_total++;
        if (!resumed) $display("FAIL alm_resume: got no request at cycle %0d, want one", a + 11);
        else n_pass++;
    endtask

    task automatic test_wrap();
        rsp_pct = 70;
        start_run(42'h3FF_FFFF_FFFE, 4);
        finish_run("wrap", 1'b0);
        n_total++;
        if (req_addr_q.size() != 4 || req_addr_q[2] !== 42'h0 || req_addr_q[3] !== 42'h1)
            $display("FAIL wrap_addr: got %0d requests, want ...FFE ...FFF 0 1", req_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_zero_lines();
        start_run(42'h40, 0);
        repeat (2) tick();
        n_total++;
        if (done_cnt != done_before + 1 || done_cyc != start_cyc + 1)
            $display("FAIL zero_done: pulses=%0d at %0d want 1 at %0d", done_cnt - done_before, done_cyc, start_cyc + 1);
        else n_pass++;
        n_total++;
        if (busy_seen || req_addr_q.size() != 0 || cycles !== '0)
            $display("FAIL zero_idle: busy_seen=%b reqs=%0d cycles=%0d want 0 0 0", busy_seen, req_addr_q.size(), cycles);
        else n_pass++;
        stray_req = 1'b1;
        repeat (3) tick();
        n_total++;
        if (err_unexpected !== 1'b0 || lines_rcvd !== '0)
            $display("FAIL idle_stray: err=%b lines=%0d want 0 0", err_unexpected, lines_rcvd);
        else n_pass++;
    endtask

    task automatic test_unexpected();
        rsp_pct     = 100;
        c0_alm_full = 1'b1;
        start_run(42'h9000, 4);
        repeat (2) tick();
        stray_req = 1'b1;
        repeat (3) tick();
        n_total++;
        if (err_unexpected !== 1'b1 || lines_rcvd !== '0)
            $display("FAIL unexp_flag: err=%b lines=%0d want 1 0", err_unexpected, lines_rcvd);
        else n_pass++;
        c0_alm_full = 1'b0;
        finish_run("unexp", 1'b1);
    endtask

    task automatic test_start_while_busy();
        rsp_pct = 50;
        start_run(42'h7000, 6);
        repeat (2) tick();
        base_addr = '0;
        num_lines = 100;
        start     = 1'b1;
        tick();
        start = 1'b0;
        finish_run("busy_start", 1'b0);
    endtask

    task automatic test_checksum();
        rsp_pct = 100;
        line_q.push_back({8{64'h1}});
        line_q.push_back({8{64'h3}});
        start_run(42'hA000, 2);
        finish_run("csum", 1'b0);
        n_total++;
        if (checksum !== 64'h0) $display("FAIL csum_fold: got %h want 0", checksum);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        for (int r = 0; r < 5; r++) begin
            rsp_pct  = $urandom_range(20, 100);
            alm_rand = 1'b1;
            b = AW'({$urandom(), $urandom()});
            start_run(b, $urandom_range(1, 40));
            finish_run($sformatf("rand%0d", r), 1'b0);
            alm_rand    = 1'b0;
            c0_alm_full = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        int reqs_at_reset;
        rsp_pct = 30;
        start_run(42'hC000, 10);
        waited = 0;
        while (rsp_cnt < 5 && waited < 500) begin
            tick();
            waited++;
        end
        n_total++;
        if (rsp_cnt < 5) $display("FAIL rst_mid_progress: got %0d responses want 5", rsp_cnt);
        else n_pass++;
        reset_n = 1'b0;
        tick();
        n_total++;
        if (c0_req_valid !== 1'b0 || c0_req_addr !== '0 || c0_req_mdata !== '0 ||
            busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_ctrl: valid=%b addr=%h mdata=%h busy=%b done=%b want 0",
                     c0_req_valid, c0_req_addr, c0_req_mdata, busy, done);
        else n_pass++;
        n_total++;
        if (lines_rcvd !== '0 || cycles !== '0 || checksum !== '0 || err_unexpected !== 1'b0)
            $display("FAIL rst_mid_stats: lines=%0d cycles=%0d sum=%h err=%b want 0",
                     lines_rcvd, cycles, checksum, err_unexpected);
        else n_pass++;
        reset_n       = 1'b1;
        rsp_pct       = 100;
        reqs_at_reset = req_addr_q.size();
        repeat (20) tick();
        n_total++;
        if (lines_rcvd !== '0 || err_unexpected !== 1'b0 || busy !== 1'b0 ||
            req_addr_q.size() != reqs_at_reset || done_cnt != done_before)
            $display("FAIL rst_mid_late: lines=%0d err=%b busy=%b new_reqs=%0d dones=%0d want 0",
                     lines_rcvd, err_unexpected, busy, req_addr_q.size() - reqs_at_reset,
                     done_cnt - done_before);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cap();
        test_alm_full();
        test_wrap();
        test_zero_lines();
        test_unexpected();
        test_start_while_busy();
        test_checksum();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ccip_rd_stream_engine
